fetch_flow_ctrl: RTL and testbench

//  Parametrised fetch-enable/redirect controller between branch predictor, ICache table and decode.

---
 rtl/fetch_flow_ctrl_if.sv | 40 ++++
 rtl/fetch_flow_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_flow_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_flow_ctrl_if.sv
// Handshake bundle between the fetch flow controller and its neighbours.
// master drives requests/redirects, slave is the controller.
interface fetch_flow_ctrl_if #(
    parameter int NUM_REDIR = 2,
    parameter int NUM_STALL = 2,
    parameter int PC_W      = 31,
    parameter int SRC_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1
);
    logic                      IN_en;
    logic [NUM_STALL-1:0]      IN_stall;
    logic                      IN_interruptPending;
    logic [PC_W-1:0]           IN_bpPC;
    logic [NUM_REDIR-1:0]      IN_redirValid;
    logic [NUM_REDIR*PC_W-1:0] IN_redirPC;
    logic [NUM_REDIR-1:0]      IN_redirWfi;
    logic                      OUT_redirValid;
    logic [PC_W-1:0]           OUT_redirPC;
    logic [SRC_W-1:0]          OUT_redirSrc;
    logic                      OUT_fetchValid;
    logic [PC_W:0]             OUT_fetchPC;
    logic [1:0]                OUT_fetchFault;
    logic [1:0]                OUT_state;
    logic [31:0]               OUT_stallCycles;

    modport master (
        output IN_en, IN_stall, IN_interruptPending, IN_bpPC,
        output IN_redirValid, IN_redirPC, IN_redirWfi,
        input  OUT_redirValid, OUT_redirPC, OUT_redirSrc,
        input  OUT_fetchValid, OUT_fetchPC, OUT_fetchFault,
        input  OUT_state, OUT_stallCycles
    );

    modport slave (
        input  IN_en, IN_stall, IN_interruptPending, IN_bpPC,
        input  IN_redirValid, IN_redirPC, IN_redirWfi,
        output OUT_redirValid, OUT_redirPC, OUT_redirSrc,
        output OUT_fetchValid, OUT_fetchPC, OUT_fetchFault,
        output OUT_state, OUT_stallCycles
    );
endinterface

// File: rtl/fetch_flow_ctrl.sv
// Fetch enable / redirect arbiter with WFI sleep and interrupt injection.
// Optional FETCH_STALL_CNT_EN adds a saturating stall-cycle counter.
module fetch_flow_ctrl #(
    parameter int NUM_REDIR = 2,
    parameter int NUM_STALL = 2,
    parameter int PC_W      = 31,
    parameter int WFI_DELAY = 1024
) (
    input  logic               clk,
    input  logic               rst,
    fetch_flow_ctrl_if.slave   bus
);
    localparam int SRC_W = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
    localparam int CNT_W = $clog2(WFI_DELAY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WFI_DELAY - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_WFI  = 2'd1,
        S_INTR = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_wfi_cnt;
    logic [CNT_W-1:0] w_wfi_cnt_nxt;

    logic             w_redir;
    logic [PC_W-1:0]  w_redir_pc;
    logic [SRC_W-1:0] w_redir_src;
    logic             w_redir_wfi;
    logic             w_base_en;
    logic             w_fetch;

    // Descending scan so the lowest set index is the last writer.
    always_comb begin
        w_redir     = 1'b0;
        w_redir_pc  = '0;
        w_redir_src = '0;
        w_redir_wfi = 1'b0;
        for (int i = NUM_REDIR - 1; i >= 0; i--) begin
            if (bus.IN_redirValid[i]) begin
                w_redir     = 1'b1;
                w_redir_pc  = bus.IN_redirPC[i*PC_W +: PC_W];
                w_redir_src = SRC_W'(i);
                w_redir_wfi = (i != 0) && bus.IN_redirWfi[i];
            end
        end
    end

    assign w_base_en = bus.IN_en && (r_state == S_RUN) && !(|bus.IN_stall);
    assign w_fetch   = !rst && w_base_en && !w_redir;

    assign bus.OUT_redirValid = !rst && w_redir;
    assign bus.OUT_redirPC    = rst ? '0 : w_redir_pc;
    assign bus.OUT_redirSrc   = rst ? '0 : w_redir_src;
    assign bus.OUT_fetchValid = w_fetch;
    assign bus.OUT_fetchPC    = {bus.IN_bpPC, 1'b0};
    assign bus.OUT_fetchFault = (w_fetch && bus.IN_interruptPending) ? 2'd1 : 2'd0;
    assign bus.OUT_state      = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RUN;
            r_wfi_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wfi_cnt <= w_wfi_cnt_nxt;
        end
    end

    // Redirect outranks WFI exit and interrupt; IN_en=0 holds everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_wfi_cnt_nxt = r_wfi_cnt;
        if (bus.IN_en) begin
            if (w_redir) begin
                if (w_redir_wfi) begin
                    w_state_nxt   = S_WFI;
                    w_wfi_cnt_nxt = CNT_LOAD;
                end else begin
                    w_state_nxt   = S_RUN;
                end
            end else begin
                unique case (r_state)
                    S_RUN: begin
                        if (w_fetch && bus.IN_interruptPending)
                            w_state_nxt = S_INTR;
                    end
                    S_WFI: begin
                        w_wfi_cnt_nxt = r_wfi_cnt - 1'b1;
                        if (bus.IN_interruptPending || r_wfi_cnt == '0)
                            w_state_nxt = S_RUN;
                    end
                    S_INTR: w_state_nxt = S_INTR;
                    default: w_state_nxt = S_RUN;
                endcase
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (bus.IN_en && r_state == S_RUN && (|bus.IN_stall)
                 && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.OUT_stallCycles = r_stall_cnt;
`else
    assign bus.OUT_stallCycles = '0;
`endif
endmodule

// File: tb/tb_fetch_flow_ctrl.sv
// Scoreboard bench for fetch_flow_ctrl (WFI_DELAY=4, two redirect sources).
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_fetch_flow_ctrl;
    localparam int PC_W = 31;

`ifdef FETCH_STALL_CNT_EN
    localparam int SCK = 1;
`else
    localparam int SCK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_flow_ctrl_if #(.NUM_REDIR(2), .NUM_STALL(2), .PC_W(PC_W)) bus ();

    fetch_flow_ctrl #(
        .NUM_REDIR(2), .NUM_STALL(2), .PC_W(PC_W), .WFI_DELAY(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string       nm;
        logic        rv;
        logic [30:0] rpc;
        logic        src;
        logic        fv;
        logic [31:0] fpc;
        logic [1:0]  flt;
        logic [1:0]  st;
        logic [31:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   done   = 1'b0;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (bus.OUT_redirValid === e.rv && bus.OUT_redirPC === e.rpc &&
                bus.OUT_redirSrc === e.src && bus.OUT_fetchValid === e.fv &&
                bus.OUT_fetchPC === e.fpc && bus.OUT_fetchFault === e.flt &&
                bus.OUT_state === e.st && bus.OUT_stallCycles === e.sc)
                n_pass++;
            else
                $display("FAIL %s: got rv=%b rpc=%h src=%b fv=%b fpc=%h flt=%0d st=%0d sc=%0d want rv=%b rpc=%h src=%b fv=%b fpc=%h flt=%0d st=%0d sc=%0d",
                    e.nm, bus.OUT_redirValid, bus.OUT_redirPC, bus.OUT_redirSrc,
                    bus.OUT_fetchValid, bus.OUT_fetchPC, bus.OUT_fetchFault,
                    bus.OUT_state, bus.OUT_stallCycles,
                    e.rv, e.rpc, e.src, e.fv, e.fpc, e.flt, e.st, e.sc);
        end
    end

    task automatic vec(
        input string nm, input bit r, input bit en, input bit [1:0] stl,
        input bit intr, input bit [1:0] rv, input bit [1:0] wf,
        input bit erv, input bit [30:0] erpc, input bit esrc,
        input bit efv, input bit [1:0] eflt, input bit [1:0] est,
        input int esc
    );
        exp_t e;
        @(posedge clk);
        #1;
        rst                     = r;
        bus.IN_en               = en;
        bus.IN_stall            = stl;
        bus.IN_interruptPending = intr;
        bus.IN_redirValid       = rv;
        bus.IN_redirWfi         = wf;
        e.nm  = nm;
        e.rv  = erv;
        e.rpc = erpc;
        e.src = esrc;
        e.fv  = efv;
        e.fpc = 32'h200;
        e.flt = eflt;
        e.st  = est;
        e.sc  = 32'(esc);
        q.push_back(e);
    endtask

    initial begin
        bus.IN_en               = 1'b1;
        bus.IN_stall            = 2'b00;
        bus.IN_interruptPending = 1'b0;
        bus.IN_bpPC             = 31'h100;
        bus.IN_redirValid       = 2'b00;
        bus.IN_redirPC          = {31'h80, 31'h40};
        bus.IN_redirWfi         = 2'b00;

        //   name        rst en stl  int rv     wf     erv rpc    src fv flt st sc
        vec("rst_drop",  1, 1, 2'b00, 0, 2'b11, 2'b00, 0, 31'h0,  0, 0, 0, 0, 0);
        vec("idle0",     0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("idle1",     0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("prio",      0, 1, 2'b00, 0, 2'b11, 2'b00, 1, 31'h40, 0, 0, 0, 0, 0);
        vec("prio_nxt",  0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("wfi_enter", 0, 1, 2'b00, 0, 2'b10, 2'b10, 1, 31'h80, 1, 0, 0, 0, 0);
        vec("wfi_c3",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("wfi_c2",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("wfi_c1",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("wfi_c0",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("wfi_exit",  0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("wake_ent",  0, 1, 2'b00, 0, 2'b10, 2'b10, 1, 31'h80, 1, 0, 0, 0, 0);
        vec("wake_w1",   0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("wake_irq",  0, 1, 2'b00, 1, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("inject",    0, 1, 2'b00, 1, 2'b00, 2'b00, 0, 31'h0,  0, 1, 1, 0, 0);
        vec("hold0",     0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 2, 0);
        vec("hold1",     0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 2, 0);
        vec("hold_rd0",  0, 1, 2'b00, 0, 2'b01, 2'b00, 1, 31'h40, 0, 0, 0, 2, 0);
        vec("hold_out",  0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("col_ent",   0, 1, 2'b00, 0, 2'b10, 2'b10, 1, 31'h80, 1, 0, 0, 0, 0);
        vec("col_c3",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("col_c2",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("col_c1",    0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 0);
        vec("col_rd0",   0, 1, 2'b00, 0, 2'b01, 2'b00, 1, 31'h40, 0, 0, 0, 1, 0);
        vec("col_run",   0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("irq_rd1",   0, 1, 2'b00, 1, 2'b10, 2'b00, 1, 31'h80, 1, 0, 0, 0, 0);
        vec("irq_rd1n",  0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);
        vec("en_off",    0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 0, 0);
        vec("stall0",    0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 0, 0);
        vec("stall1",    0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 0, SCK);
        vec("stall2",    0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 0, 2*SCK);
        vec("stall_end", 0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 3*SCK);
        vec("rw_ent",    0, 1, 2'b00, 0, 2'b10, 2'b10, 1, 31'h80, 1, 0, 0, 0, 3*SCK);
        vec("rw_c3",     0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 0, 0, 1, 3*SCK);
        vec("rw_rst",    1, 1, 2'b00, 0, 2'b10, 2'b10, 0, 31'h0,  0, 0, 0, 1, 3*SCK);
        vec("rw_after",  0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 31'h0,  0, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d vectors left, want 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
